// File: rtl/vga_pkg.sv
// Shared types and defaults for the VGA frame capture block.
package vga_pkg;

  localparam int H_ACTIVE_DEFAULT = 640;
  localparam int V_ACTIVE_DEFAULT = 480;

  localparam logic [9:0] X_MAX = 10'd1023;
  localparam logic [8:0] Y_MAX = 9'd511;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE
  } cap_state_t;

  typedef struct packed {
    logic [2:0] red;
    logic [2:0] green;
    logic [1:0] blue;
  } pixel_t;

endpackage

// File: rtl/vga_sync_edge.sv
// Registers sync/enable inputs; fall pulses compare registered vs live.
module vga_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic h_sync,
  input  logic v_sync,
  input  logic video_enable,
  output logic hs_r,
  output logic ve_r,
  output logic vs_fall,
  output logic ve_fall
);

  logic hs_d, vs_d, ve_d;
  logic hs_q, vs_q, ve_q;

  always_comb begin
    hs_d = h_sync;
    vs_d = v_sync;
    ve_d = video_enable;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_q <= 1'b0;
      vs_q <= 1'b0;
      ve_q <= 1'b0;
    end else begin
      hs_q <= hs_d;
      vs_q <= vs_d;
      ve_q <= ve_d;
    end
  end

  assign hs_r    = hs_q;
  assign ve_r    = ve_q;
  assign vs_fall = vs_q & ~v_sync;
  assign ve_fall = ve_q & ~video_enable;

endmodule

// File: rtl/vga_frame_capture.sv
// Captures one (or back-to-back) VGA frames into a pixel stream
// with per-frame count/checksum and sticky geometry error flags.
module vga_frame_capture
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEFAULT,
  parameter int V_ACTIVE = V_ACTIVE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        h_sync,
  input  logic        v_sync,
  input  logic [2:0]  red,
  input  logic [2:0]  green,
  input  logic [1:0]  blue,
  input  logic        video_enable,
  input  logic        arm,
  input  logic        continuous,
  output logic        pixel_valid,
  output logic [7:0]  pixel_data,
  output logic [9:0]  pixel_x,
  output logic [8:0]  pixel_y,
  output logic        busy,
  output logic        frame_done,
  output logic [18:0] pixel_count,
  output logic [15:0] frame_checksum,
  output logic        line_error,
  output logic        frame_error
);

  localparam logic [9:0] H_LIM = 10'(H_ACTIVE);
  localparam logic [8:0] V_LIM = 9'(V_ACTIVE);

  logic hs_r, ve_r, vs_fall, ve_fall;

  vga_sync_edge u_sync (
    .clk          (clk),
    .rst          (rst),
    .h_sync       (h_sync),
    .v_sync       (v_sync),
    .video_enable (video_enable),
    .hs_r         (hs_r),
    .ve_r         (ve_r),
    .vs_fall      (vs_fall),
    .ve_fall      (ve_fall)
  );

  cap_state_t  state_d, state_q;
  pixel_t      pix_d, pix_q;
  logic        arm_d, arm_q;
  logic        cont_d, cont_q;
  logic [9:0]  x_d, x_q, x_n;
  logic [8:0]  y_d, y_q, y_n;
  logic [18:0] cnt_d, cnt_q, cnt_n;
  logic [15:0] sum_d, sum_q, sum_n;
  logic        hs_seen_d, hs_seen_q, hs_n;
  logic        pv_d, pv_q;
  logic [7:0]  pd_d, pd_q;
  logic [9:0]  px_d, px_q;
  logic [8:0]  py_d, py_q;
  logic        busy_d, busy_q;
  logic        done_d, done_q;
  logic [18:0] count_d, count_q;
  logic [15:0] csum_d, csum_q;
  logic        lerr_d, lerr_q;
  logic        ferr_d, ferr_q;
  logic        pix;

  assign pix = (state_q == CAPTURE) && ve_r;

  always_comb begin
    pix_d     = '{red: red, green: green, blue: blue};
    arm_d     = arm;
    cont_d    = continuous;
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    hs_seen_d = hs_seen_q;
    lerr_d    = lerr_q;
    ferr_d    = ferr_q;
    count_d   = count_q;
    csum_d    = csum_q;
    done_d    = 1'b0;
    pv_d      = pix;
    pd_d      = pd_q;
    px_d      = px_q;
    py_d      = py_q;
    x_n       = x_q;
    y_n       = y_q;
    cnt_n     = cnt_q;
    sum_n     = sum_q;
    hs_n      = hs_seen_q | ~hs_r;
    if (pix) begin
      pd_d = pix_q;
      px_d = x_q;
      py_d = y_q;
    end
    unique case (state_q)
      IDLE: begin
        if (arm_q) begin
          state_d = ARMED;
          lerr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      ARMED: begin
        if (vs_fall) begin
          state_d   = CAPTURE;
          x_d       = '0;
          y_d       = '0;
          cnt_d     = '0;
          sum_d     = '0;
          hs_seen_d = 1'b0;
        end
      end
      CAPTURE: begin
        if (pix) begin
          cnt_n = cnt_q + 19'd1;
          sum_n = sum_q + {8'd0, pix_q};
          if (x_q == X_MAX) lerr_d = 1'b1;
          else              x_n    = x_q + 10'd1;
        end
        // Line end shares a cycle with its last pixel.
        if (ve_fall) begin
          if (x_n != H_LIM || !hs_n) lerr_d = 1'b1;
          x_n  = '0;
          hs_n = 1'b0;
          if (y_q == Y_MAX) ferr_d = 1'b1;
          else              y_n    = y_q + 9'd1;
        end
        x_d       = x_n;
        y_d       = y_n;
        cnt_d     = cnt_n;
        sum_d     = sum_n;
        hs_seen_d = hs_n;
        if (vs_fall) begin
          done_d    = 1'b1;
          count_d   = cnt_n;
          csum_d    = sum_n;
          if (y_n != V_LIM) ferr_d = 1'b1;
          x_d       = '0;
          y_d       = '0;
          cnt_d     = '0;
          sum_d     = '0;
          hs_seen_d = 1'b0;
          state_d   = cont_q ? CAPTURE : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pix_q     <= '0;
      arm_q     <= 1'b0;
      cont_q    <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      cnt_q     <= '0;
      sum_q     <= '0;
      hs_seen_q <= 1'b0;
      pv_q      <= 1'b0;
      pd_q      <= '0;
      px_q      <= '0;
      py_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      count_q   <= '0;
      csum_q    <= '0;
      lerr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pix_q     <= pix_d;
      arm_q     <= arm_d;
      cont_q    <= cont_d;
      x_q       <= x_d;
      y_q       <= y_d;
      cnt_q     <= cnt_d;
      sum_q     <= sum_d;
      hs_seen_q <= hs_seen_d;
      pv_q      <= pv_d;
      pd_q      <= pd_d;
      px_q      <= px_d;
      py_q      <= py_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      count_q   <= count_d;
      csum_q    <= csum_d;
      lerr_q    <= lerr_d;
      ferr_q    <= ferr_d;
    end
  end

  assign pixel_valid    = pv_q;
  assign pixel_data     = pd_q;
  assign pixel_x        = px_q;
  assign pixel_y        = py_q;
  assign busy           = busy_q;
  assign frame_done     = done_q;
  assign pixel_count    = count_q;
  assign frame_checksum = csum_q;
  assign line_error     = lerr_q;
  assign frame_error    = ferr_q;

endmodule

// File: doc/vga_frame_capture.md
VGA_FRAME_CAPTURE -- requirements
Module: vga_frame_capture

Interface
REQ-001 The module SHALL have one clock and an asynchronous active-high reset: `clk` (input, 1, pixel clock shared with graphics_card) and `rst` (input, 1, async active-high reset).
REQ-002 It SHALL have parameter `H_ACTIVE`, default 640, meaning active pixels per line.
REQ-003 It SHALL have parameter `V_ACTIVE`, default 480, meaning active lines per frame.
REQ-004 Port `h_sync`: input, 1 bit, active-low horizontal sync.
REQ-005 Port `v_sync`: input, 1 bit, active-low vertical sync; its falling edge marks a frame boundary.
REQ-006 Ports `red`, `green`, `blue`: inputs, 3/3/2 bits, pixel colour.
REQ-007 Port `video_enable`: input, 1 bit, high during active pixels.
REQ-008 Port `arm`: input, 1 bit, single-cycle request to capture the next full frame.
REQ-009 Port `continuous`: input, 1 bit; when high at frame end, capture restarts immediately.
REQ-010 Port `pixel_valid`: output, 1 bit, captured-pixel strobe.
REQ-011 Port `pixel_data`: output, 8 bits, {red,green,blue}.
REQ-012 Ports `pixel_x` and `pixel_y`: outputs, 10/9 bits, coordinates of `pixel_data`.
REQ-013 Port `busy`: output, 1 bit, high while ARMED or CAPTURE.
REQ-014 Port `frame_done`: output, 1 bit, one-cycle pulse at frame end.
REQ-015 Ports `pixel_count` and `frame_checksum`: outputs, 19/16 bits, latched results of the last frame.
REQ-016 Ports `line_error` and `frame_error`: outputs, 1 bit each, sticky until the next arm.

Function
REQ-017 All inputs except `clk`/`rst` SHALL be registered once; a v_sync falling edge is detected as registered 1 -> current 0.
REQ-018 The FSM SHALL have states IDLE, ARMED and CAPTURE.
REQ-019 IDLE SHALL go to ARMED on `arm`, clearing `line_error`/`frame_error`; `arm` in any other state SHALL be ignored.
REQ-020 ARMED SHALL go to CAPTURE on a v_sync falling edge; an `arm` and a falling edge in the same cycle in IDLE SHALL go to ARMED only.
REQ-021 On entering CAPTURE, x, y, running count and running checksum SHALL be zeroed.
REQ-022 In CAPTURE, for each cycle with registered `video_enable` high, `pixel_valid` SHALL assert one cycle later with `pixel_data`, `pixel_x`=x and `pixel_y`=y; x then increments.
REQ-023 A falling edge of registered `video_enable` SHALL end the line: x != `H_ACTIVE` sets `line_error`; x resets to 0; y increments.
REQ-024 Running count SHALL increment per valid pixel; running checksum SHALL be the sum of `pixel_data` modulo 2^16.
REQ-025 x SHALL saturate at 1023 and y at 511 (no wrap), with the error flag set.
REQ-026 A v_sync falling edge in CAPTURE SHALL pulse `frame_done`, latch `pixel_count`/`frame_checksum` in that cycle, and set `frame_error` if lines != `V_ACTIVE`.
REQ-027 At that edge, `continuous`=1 SHALL re-enter CAPTURE with cleared counters (error flags kept sticky); otherwise the FSM SHALL go to IDLE.
REQ-028 A pixel accepted in the same cycle as the v_sync edge SHALL belong to the ending frame.
REQ-029 `h_sync` SHALL be used only to qualify the line end: a line end without h_sync low seen since the previous line end sets `line_error`.

Reset
REQ-030 On `rst` the FSM SHALL go to IDLE and all outputs, counters, flags and input registers SHALL be 0, taking effect immediately (asynchronously), including mid-capture.
REQ-031 After reset release, no `frame_done` SHALL occur without a new `arm`.

Structure
REQ-032 Package `vga_pkg` SHALL hold `H_ACTIVE`/`V_ACTIVE` defaults, the capture state enum typedef and the pixel struct {red, green, blue}.
REQ-033 One sub-module `vga_sync_edge` SHALL register the sync and enable inputs and output rise/fall pulses; everything else stays in `vga_frame_capture`.

Verification
REQ-034 Arm, then a full 640x480 frame of 0xFF -> `frame_done` once, `pixel_count`=307200, `frame_checksum`=0x5000, no errors.
REQ-035 An all-0x00 frame -> checksum 0x0000, count 307200; final `pixel_x`=639 and `pixel_y`=479 on the last valid pixel.
REQ-036 Line 5 has 639 pixels -> `line_error`=1, count 307199; only the next `arm` clears the flag.
REQ-037 Arm mid-frame -> no `pixel_valid` until the next v_sync fall; capture covers exactly the following frame.
REQ-038 `continuous`=1 over 3 frames -> 3 `frame_done` pulses with no gap; each latched count is 307200.
REQ-039 `rst` asserted at line 200 of capture -> outputs 0 at once, state IDLE, and no `frame_done` afterwards until re-armed.
